uart_rx: RTL

//  Receive stage paired with the UART transmitter: consumes the serial line (o_Tx_Serial of the tx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_sync.sv | 22 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam int UART_DATA_W         = 8;
    localparam int UART_BITS_PER_FRAME = 10;

    typedef enum logic [2:0] {
        s_IDLE    = 3'd0,
        s_START   = 3'd1,
        s_DATA    = 3'd2,
        s_STOP    = 3'd3,
        s_CLEANUP = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line.
// Both flops reset to 1 so a reset line reads as idle.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-sampled, byte strobe plus framing-error strobe.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling at each sample point.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_W);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [IW-1:0] TOP  = IW'(UART_DATA_W - 1);

    uart_state_t            state;
    logic [CW-1:0]          count;
    logic [IW-1:0]          bit_idx;
    logic [UART_DATA_W-1:0] shift;
    logic                   r_Rx;
    logic                   sample;

    uart_rx_sync u_sync (
        .clk   (i_Clock),
        .rst_n (i_Rst_L),
        .d     (i_Rx_Serial),
        .q     (r_Rx)
    );

`ifdef UART_RX_MAJORITY_EN
    // hist holds r_Rx from one and two cycles back
    logic [1:0] hist;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], r_Rx};
        end
    end

    assign sample = (hist[1] & hist[0]) |
                    (hist[1] & r_Rx)    |
                    (hist[0] & r_Rx);
`else
    assign sample = r_Rx;
`endif

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state          <= s_IDLE;
            count          <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            o_Rx_DV        <= 1'b0;
            o_Rx_Byte      <= 8'h00;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
        end else begin
            unique case (state)
                s_IDLE: begin
                    count   <= '0;
                    bit_idx <= '0;
                    if (!r_Rx) begin
                        state <= s_START;
                    end
                end
                s_START: begin
                    if (count == HALF) begin
                        count <= '0;
                        if (!sample) begin
                            o_Rx_Active <= 1'b1;
                            state       <= s_DATA;
                        end else begin
                            state <= s_IDLE;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                s_DATA: begin
                    if (count == LAST) begin
                        count          <= '0;
                        shift[bit_idx] <= sample;
                        if (bit_idx == TOP) begin
                            state <= s_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                s_STOP: begin
                    if (count == LAST) begin
                        count <= '0;
                        if (sample) begin
                            o_Rx_Byte <= shift;
                            o_Rx_DV   <= 1'b1;
                        end else begin
                            o_Rx_Frame_Err <= 1'b1;
                        end
                        state <= s_CLEANUP;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                s_CLEANUP: begin
                    o_Rx_DV        <= 1'b0;
                    o_Rx_Frame_Err <= 1'b0;
                    o_Rx_Active    <= 1'b0;
                    state          <= s_IDLE;
                end
                default: begin
                    state <= s_IDLE;
                end
            endcase
        end
    end

endmodule
